// File: rtl/mux_nt1_scan.sv
// Registered N-to-1 word selector with manual, auto-scan, freeze and single-step modes.
// out and cur_sel always load together, so cur_sel names the channel currently shown on out.
module mux_nt1_scan #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CHANNELS    = 16,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned SCAN_PERIOD = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          s,
  input  logic                      step,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      valid,
  output logic                      sel_err
);

  localparam logic [1:0] ModeManual = 2'b00;
  localparam logic [1:0] ModeScan   = 2'b01;
  localparam logic [1:0] ModeFreeze = 2'b10;
  localparam logic [1:0] ModeStep   = 2'b11;

  localparam int unsigned DivW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_PERIOD - 1);

  // One extra bit so CHANNELS == 2**SEL_W is representable.
  localparam logic [SEL_W:0] NumCh  = CHANNELS[SEL_W:0];
  localparam logic [SEL_W:0] ChLast = NumCh - 1'b1;

  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic             valid_q, valid_d;
  logic             sel_err_q, sel_err_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             load;
  logic [WIDTH-1:0] word;

  // Wraps at the last channel; an out-of-range index also recovers to 0.
  function automatic logic [SEL_W-1:0] inc_sel(input logic [SEL_W-1:0] x);
    if ({1'b0, x} >= ChLast) begin
      return '0;
    end
    return x + SEL_W'(1);
  endfunction

  always_comb begin
    cur_sel_d = cur_sel_q;
    valid_d   = valid_q;
    sel_err_d = sel_err_q;
    div_d     = '0;
    load      = 1'b1;
    unique case (mode)
      ModeManual: begin
        cur_sel_d = s;
        valid_d   = 1'b1;
        sel_err_d = ({1'b0, s} >= NumCh);
      end
      ModeScan: begin
        if (div_q == DivLast) begin
          cur_sel_d = inc_sel(cur_sel_q);
        end else begin
          div_d = div_q + DivW'(1);
        end
        valid_d   = 1'b1;
        sel_err_d = 1'b0;
      end
      ModeFreeze: begin
        load  = 1'b0;
        div_d = div_q;
      end
      ModeStep: begin
        if (step) begin
          cur_sel_d = inc_sel(cur_sel_q);
        end
        valid_d   = 1'b1;
        sel_err_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cur_sel_d == SEL_W'(k)) begin
        word = in_bus[k*WIDTH +: WIDTH];
      end
    end
    out_d = load ? word : out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      cur_sel_q <= '0;
      valid_q   <= 1'b0;
      sel_err_q <= 1'b0;
      div_q     <= '0;
    end else begin
      out_q     <= out_d;
      cur_sel_q <= cur_sel_d;
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
      div_q     <= div_d;
    end
  end

  assign out     = out_q;
  assign cur_sel = cur_sel_q;
  assign valid   = valid_q;
  assign sel_err = sel_err_q;

endmodule
